// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory-access unit: one-hot load/store field layout,
// FSM state encoding and the load size code passed to the extension block.
package mem_access_unit_pkg;

    // Bit positions inside the 11-bit one-hot load/store field
    localparam int unsigned LS_LB  = 0;
    localparam int unsigned LS_LH  = 1;
    localparam int unsigned LS_LW  = 2;
    localparam int unsigned LS_LD  = 3;
    localparam int unsigned LS_LBU = 4;
    localparam int unsigned LS_LHU = 5;
    localparam int unsigned LS_LWU = 6;
    localparam int unsigned LS_SB  = 7;
    localparam int unsigned LS_SH  = 8;
    localparam int unsigned LS_SW  = 9;
    localparam int unsigned LS_SD  = 10;

    localparam int unsigned LS_W = 11;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        SzByte,
        SzHalf,
        SzWord,
        SzDouble
    } size_e;

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-cache request/response channel: one valid/ready request, single-cycle response pulse.
interface mem_access_unit_if #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned ADDR_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic [7:0]        req_wstrb;
    logic              resp_valid;
    logic [XLEN-1:0]   resp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Byte-lane select and sign/zero extension of an aligned 64-bit read word.
module mem_access_unit_load_extend
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [2:0]      off_i,
    input  size_e           size_i,
    input  logic            unsigned_i,
    output logic [XLEN-1:0] data_o
);
    logic [XLEN-1:0] shifted;

    // Move the addressed lane down to bit 0; accesses are aligned so nothing wraps
    assign shifted = rdata_i >> {off_i, 3'b000};

    // Extend the selected lane to full width
    always_comb begin
        data_o = shifted;
        unique case (size_i)
            SzByte:   data_o = unsigned_i ? XLEN'(shifted[7:0])
                                          : XLEN'($signed(shifted[7:0]));
            SzHalf:   data_o = unsigned_i ? XLEN'(shifted[15:0])
                                          : XLEN'($signed(shifted[15:0]));
            SzWord:   data_o = unsigned_i ? XLEN'(shifted[31:0])
                                          : XLEN'($signed(shifted[31:0]));
            SzDouble: data_o = rdata_i;
            default:  data_o = rdata_i;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: decodes the one-hot load/store field, issues one cache request per
// access, stalls until the response and returns extended load data.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LS_W-1:0]   regM_o_load_store_info,
    input  logic [ADDR_W-1:0] regM_o_alu_result,
    input  logic [XLEN-1:0]   regM_o_regdata2,
    input  logic              mem_i_hold,
    mem_access_unit_if.master dcache,
    output logic              memory_o_stall,
    output logic [XLEN-1:0]   memory_o_load_data,
    output logic              memory_o_misalign
);
    state_e          state_q, state_d;
    logic [XLEN-1:0] load_data_q;
    logic            is_load_q;
    size_e           size_q;
    logic            unsigned_q;
    logic [2:0]      off_q;

    logic [LS_W-1:0] ls;
    logic            is_b, is_h, is_w, is_d, is_store, is_any, is_uns, mem_op;
    logic [2:0]      off;
    logic [7:0]      strb_base;
    size_e           size;
    logic            issue, capture, req_valid;
    logic [XLEN-1:0] ext_data;

    assign ls       = regM_o_load_store_info;
    assign off      = regM_o_alu_result[2:0];
    assign is_b     = ls[LS_LB] | ls[LS_LBU] | ls[LS_SB];
    assign is_h     = ls[LS_LH] | ls[LS_LHU] | ls[LS_SH];
    assign is_w     = ls[LS_LW] | ls[LS_LWU] | ls[LS_SW];
    assign is_d     = ls[LS_LD] | ls[LS_SD];
    assign is_store = ls[LS_SB] | ls[LS_SH] | ls[LS_SW] | ls[LS_SD];
    assign is_uns   = ls[LS_LBU] | ls[LS_LHU] | ls[LS_LWU];
    assign is_any   = |ls;

    assign memory_o_misalign = (is_h && off[0]) | (is_w && off[1:0] != 2'b00) |
                               (is_d && off != 3'b000);
    assign mem_op = is_any && !memory_o_misalign;

    // Access size and base strobe pattern from the one-hot decode
    always_comb begin
        size      = SzByte;
        strb_base = 8'h00;
        if (is_h) begin
            size      = SzHalf;
            strb_base = 8'h03;
        end else if (is_w) begin
            size      = SzWord;
            strb_base = 8'h0F;
        end else if (is_d) begin
            size      = SzDouble;
            strb_base = 8'hFF;
        end else if (is_b) begin
            strb_base = 8'h01;
        end
    end

    assign dcache.req_we    = is_store;
    assign dcache.req_addr  = {regM_o_alu_result[ADDR_W-1:3], 3'b000};
    assign dcache.req_wdata = is_store ? (regM_o_regdata2 << {off, 3'b000}) : '0;
    assign dcache.req_wstrb = is_store ? (strb_base << off) : 8'h00;
    assign dcache.req_valid = req_valid;

    // Next-state and handshake outputs; inputs are only sampled in idle, so an op that
    // is still held in regM during done is never reissued
    always_comb begin
        state_d        = state_q;
        req_valid      = 1'b0;
        memory_o_stall = 1'b0;
        issue          = 1'b0;
        capture        = 1'b0;
        unique case (state_q)
            StIdle: begin
                req_valid      = mem_op;
                memory_o_stall = mem_op;
                if (mem_op && dcache.req_ready) begin
                    issue   = 1'b1;
                    state_d = StWait;
                end
            end
            StWait: begin
                memory_o_stall = 1'b1;
                if (dcache.resp_valid) begin
                    capture = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (!mem_i_hold) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    mem_access_unit_load_extend #(
        .XLEN (XLEN)
    ) u_load_extend (
        .rdata_i    (dcache.resp_rdata),
        .off_i      (off_q),
        .size_i     (size_q),
        .unsigned_i (unsigned_q),
        .data_o     (ext_data)
    );

    // State register, per-request attributes latched at issue, load result capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            load_data_q <= '0;
            is_load_q   <= 1'b0;
            size_q      <= SzByte;
            unsigned_q  <= 1'b0;
            off_q       <= 3'b000;
        end else begin
            state_q <= state_d;
            if (issue) begin
                is_load_q  <= !is_store;
                size_q     <= size;
                unsigned_q <= is_uns;
                off_q      <= off;
            end
            if (capture && is_load_q) load_data_q <= ext_data;
        end
    end

    assign memory_o_load_data = load_data_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a simple in-line cache responder.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] lsi = '0;
    logic [63:0] alu = '0;
    logic [63:0] rd2 = '0;
    logic        hold = 1'b0;
    logic        stall;
    logic        misalign;
    logic [63:0] ld_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_access_unit_if #(.XLEN(64), .ADDR_W(64)) dc_if ();

    mem_access_unit #(
        .XLEN   (64),
        .ADDR_W (64)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .regM_o_load_store_info (lsi),
        .regM_o_alu_result      (alu),
        .regM_o_regdata2        (rd2),
        .mem_i_hold             (hold),
        .dcache                 (dc_if),
        .memory_o_stall         (stall),
        .memory_o_load_data     (ld_data),
        .memory_o_misalign      (misalign)
    );

    // More than one set bit in the field is illegal stimulus
    always @(negedge clk) begin
        assert ($onehot0(lsi)) else $error("illegal load_store_info %b", lsi);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] op(input int unsigned idx);
        logic [10:0] one;
        one = 11'd1;
        return one << idx;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Present an op in idle with ready low and check the request fields; starts/ends at +1
    task automatic check_req(input string tag, input logic [10:0] o, input logic [63:0] a,
                             input logic [63:0] wd, input logic exp_we,
                             input logic [63:0] exp_addr, input logic [63:0] exp_wdata,
                             input logic [7:0] exp_strb);
        lsi = o; alu = a; rd2 = wd; dc_if.req_ready = 1'b0;
        #2;
        check({tag, "_valid"}, 64'(dc_if.req_valid), 64'd1);
        check({tag, "_we"},    64'(dc_if.req_we), 64'(exp_we));
        check({tag, "_addr"},  dc_if.req_addr, exp_addr);
        check({tag, "_wdata"}, dc_if.req_wdata, exp_wdata);
        check({tag, "_wstrb"}, 64'(dc_if.req_wstrb), 64'(exp_strb));
        next_cycle();
        lsi = '0;
    endtask

    // Run one access to done; starts at +1, returns at +3 of the first done cycle
    task automatic do_op(input logic [10:0] o, input logic [63:0] a, input logic [63:0] wd,
                         input int ready_lat, input int resp_lat, input logic [63:0] rdata,
                         output int stall_cyc, output int hs_cnt);
        int h;
        bit done;
        h = -1; done = 1'b0; stall_cyc = 0; hs_cnt = 0;
        lsi = o; alu = a; rd2 = wd; dc_if.resp_rdata = rdata;
        for (int c = 0; c < 40 && !done; c++) begin
            dc_if.req_ready  = (c >= ready_lat);
            dc_if.resp_valid = (h >= 0) && (c == h + resp_lat);
            #2;
            if (h >= 0 && !stall) begin
                done = 1'b1;
            end else begin
                if (stall) stall_cyc++;
                if (dc_if.req_valid && dc_if.req_ready) begin
                    hs_cnt++;
                    if (h < 0) h = c;
                end
                next_cycle();
            end
        end
        dc_if.req_ready = 1'b0;
        dc_if.resp_valid = 1'b0;
        if (!done) check("op_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int sc, hs;
        logic [10:0] t_op   [4];
        logic [63:0] t_addr [4];
        logic [63:0] t_rd   [4];
        logic [63:0] t_exp  [4];

        dc_if.req_ready  = 1'b0;
        dc_if.resp_valid = 1'b0;
        dc_if.resp_rdata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #3;
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_valid", 64'(dc_if.req_valid), 64'd0);
        check("rst_ldata", ld_data, 64'd0);
        rst = 1'b1;
        next_cycle();

        // lb with sign extension from lane 3
        check_req("lb_req", op(LS_LB), 64'h1003, 64'd0, 1'b0, 64'h1000, 64'd0, 8'h00);
        do_op(op(LS_LB), 64'h1003, 64'd0, 0, 1, 64'h0000_0000_8000_0000, sc, hs);
        check("lb_stall_cyc", 64'(sc), 64'd2);
        check("lb_hs", 64'(hs), 64'd1);
        check("lb_ldata", ld_data, 64'hFFFF_FFFF_FFFF_FF80);
        next_cycle();
        lsi = '0;
        #2;
        check("nop_stall", 64'(stall), 64'd0);
        check("nop_ldata_hold", ld_data, 64'hFFFF_FFFF_FFFF_FF80);
        next_cycle();

        // Other load widths and extension kinds
        t_op[0] = op(LS_LHU); t_addr[0] = 64'h5002; t_rd[0] = 64'h0000_0000_F00D_0000;
        t_exp[0] = 64'h0000_0000_0000_F00D;
        t_op[1] = op(LS_LH);  t_addr[1] = 64'h5002; t_rd[1] = 64'h0000_0000_F00D_0000;
        t_exp[1] = 64'hFFFF_FFFF_FFFF_F00D;
        t_op[2] = op(LS_LBU); t_addr[2] = 64'h6007; t_rd[2] = 64'hFE00_0000_0000_0000;
        t_exp[2] = 64'h0000_0000_0000_00FE;
        t_op[3] = op(LS_LWU); t_addr[3] = 64'h6004; t_rd[3] = 64'h89AB_CDEF_0000_0000;
        t_exp[3] = 64'h0000_0000_89AB_CDEF;
        for (int i = 0; i < 4; i++) begin
            do_op(t_op[i], t_addr[i], 64'd0, 0, 1, t_rd[i], sc, hs);
            check($sformatf("ld_tbl%0d", i), ld_data, t_exp[i]);
            next_cycle();
            lsi = '0;
        end

        // Stores: lane shift and strobes
        check_req("sh_req", op(LS_SH), 64'h2006, 64'h1234, 1'b1, 64'h2000,
                  64'h1234_0000_0000_0000, 8'hC0);
        check_req("sb_req", op(LS_SB), 64'h7005, 64'hAB, 1'b1, 64'h7000,
                  64'h0000_AB00_0000_0000, 8'h20);
        check_req("sw_req", op(LS_SW), 64'h700C, 64'hDEAD_BEEF, 1'b1, 64'h7008,
                  64'hDEAD_BEEF_0000_0000, 8'hF0);
        check_req("sd_req", op(LS_SD), 64'h7010, 64'h0123_4567_89AB_CDEF, 1'b1, 64'h7010,
                  64'h0123_4567_89AB_CDEF, 8'hFF);
        do_op(op(LS_SH), 64'h2006, 64'h1234, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, sc, hs);
        check("sh_hs", 64'(hs), 64'd1);
        check("sh_ldata_kept", ld_data, 64'h0000_0000_89AB_CDEF);
        next_cycle();
        lsi = '0;

        // ld with slow ready and 2-cycle response
        do_op(op(LS_LD), 64'h8000, 64'd0, 3, 2, 64'hDEAD_BEEF_CAFE_F00D, sc, hs);
        check("ld_stall_cyc", 64'(sc), 64'd6);
        check("ld_hs", 64'(hs), 64'd1);
        check("ld_done_stall", 64'(stall), 64'd0);
        check("ld_ldata", ld_data, 64'hDEAD_BEEF_CAFE_F00D);
        next_cycle();
        lsi = '0;

        // lw held in done for 4 cycles
        do_op(op(LS_LW), 64'h1004, 64'd0, 0, 1, 64'h89AB_CDEF_1234_5678, sc, hs);
        check("lw_ldata", ld_data, 64'hFFFF_FFFF_89AB_CDEF);
        dc_if.req_ready = 1'b1;
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            #2;
            check($sformatf("hold%0d_valid", i), 64'(dc_if.req_valid), 64'd0);
            check($sformatf("hold%0d_stall", i), 64'(stall), 64'd0);
            check($sformatf("hold%0d_ldata", i), ld_data, 64'hFFFF_FFFF_89AB_CDEF);
        end
        hold = 1'b0;
        dc_if.req_ready = 1'b0;
        next_cycle();
        lsi = '0;

        // Misalignment detection
        dc_if.req_ready = 1'b1;
        lsi = op(LS_LW); alu = 64'h3002;
        #2;
        check("mis_lw_flag", 64'(misalign), 64'd1);
        check("mis_lw_valid", 64'(dc_if.req_valid), 64'd0);
        check("mis_lw_stall", 64'(stall), 64'd0);
        next_cycle();
        #2;
        check("mis_lw_stall2", 64'(stall), 64'd0);
        dc_if.req_ready = 1'b0;
        lsi = op(LS_LH); alu = 64'h3001;
        #1;
        check("mis_lh_flag", 64'(misalign), 64'd1);
        lsi = op(LS_LD); alu = 64'h3004;
        #1;
        check("mis_ld_flag", 64'(misalign), 64'd1);
        lsi = op(LS_LW); alu = 64'h3004;
        #1;
        check("ok_lw_flag", 64'(misalign), 64'd0);
        lsi = '0;
        next_cycle();

        // Reset while waiting for a response
        lsi = op(LS_LD); alu = 64'h4000; dc_if.req_ready = 1'b1;
        #2;
        check("rw_req_valid", 64'(dc_if.req_valid), 64'd1);
        next_cycle();
        dc_if.req_ready = 1'b0;
        #2;
        check("rw_wait_stall", 64'(stall), 64'd1);
        rst = 1'b0;
        lsi = '0;
        #1;
        check("rw_rst_stall", 64'(stall), 64'd0);
        check("rw_rst_ldata", ld_data, 64'd0);
        next_cycle();
        rst = 1'b1;
        dc_if.resp_valid = 1'b1;
        dc_if.resp_rdata = 64'h5555_AAAA_5555_AAAA;
        #2;
        check("late_resp_stall", 64'(stall), 64'd0);
        next_cycle();
        dc_if.resp_valid = 1'b0;
        #2;
        check("late_resp_ldata", ld_data, 64'd0);
        next_cycle();
        do_op(op(LS_LD), 64'h4008, 64'd0, 0, 1, 64'h1122_3344_5566_7788, sc, hs);
        check("post_rst_hs", 64'(hs), 64'd1);
        check("post_rst_ldata", ld_data, 64'h1122_3344_5566_7788);
        next_cycle();
        lsi = '0;
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
